// File: rtl/game_command_receiver_pkg.sv
// Shared constants for the game command path: game FSM encodings, frame marker,
// opcodes and the receiver FSM state type.
package game_command_receiver_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT      = 8'hAA;
  localparam int         TIMEOUT_CYCLES_DEFAULT = 1_000_000;

  // Game FSM encodings, also used by the transmit-side controller
  localparam logic [2:0] INICIAR_JOGO           = 3'b000;
  localparam logic [2:0] SELECIONAR_DIFICULDADE = 3'b001;
  localparam logic [2:0] CARREGANDO             = 3'b010;
  localparam logic [2:0] CORRENDO_MAPA          = 3'b011;
  localparam logic [2:0] PERCORRER_NUMEROS      = 3'b100;
  localparam logic [2:0] VITORIA                = 3'b101;
  localparam logic [2:0] DERROTA                = 3'b110;

  localparam logic [7:0] OP_START         = 8'h01;
  localparam logic [7:0] OP_DIFFICULTY    = 8'h02;
  localparam logic [7:0] OP_MOVE          = 8'h03;
  localparam logic [7:0] OP_SELECT_NUMBER = 8'h04;
  localparam logic [7:0] OP_CONFIRM       = 8'h05;

  typedef enum logic [1:0] {
    S_WAIT_SYNC   = 2'd0,
    S_GET_CMD     = 2'd1,
    S_GET_PAYLOAD = 2'd2,
    S_GET_CHECK   = 2'd3
  } rx_state_e;

  // Gameplay commands (move/number/confirm) share the same legal states
  function automatic logic in_play_state(input logic [2:0] st);
    return (st == CORRENDO_MAPA) || (st == PERCORRER_NUMEROS);
  endfunction

  function automatic logic number_in_range(input logic [7:0] p);
    return (p >= 8'd1) && (p <= 8'd9);
  endfunction

endpackage

// File: rtl/game_command_receiver_rx_timeout_counter.sv
// Inter-byte idle counter: counts while enabled, clears on any accepted byte,
// strobes expired for one cycle on the TIMEOUT_CYCLES-th idle clock.
module rx_timeout_counter
  import game_command_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // An accepted byte on the terminal cycle wins over the timeout
  assign expired = enable && !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || !enable || expired) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_command_receiver.sv
// Parses SYNC/CMD/PAYLOAD/CHECK frames from the UART RX byte stream into one-cycle
// game-input events, gated by the game FSM state; never applies backpressure.
module game_command_receiver
  import game_command_receiver_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic [2:0] current_state,
  output logic       start_pulse,
  output logic       dificulty_valid,
  output logic       dificulty,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       number_valid,
  output logic [3:0] number,
  output logic       confirm_pulse,
  output logic       frame_error,
  output logic       rejected
);

  rx_state_e  state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] payload_q, payload_d;

  logic       start_pulse_q, start_pulse_d;
  logic       dificulty_valid_q, dificulty_valid_d;
  logic       dificulty_q, dificulty_d;
  logic       move_valid_q, move_valid_d;
  logic [1:0] move_dir_q, move_dir_d;
  logic       number_valid_q, number_valid_d;
  logic [3:0] number_q, number_d;
  logic       confirm_pulse_q, confirm_pulse_d;
  logic       frame_error_q, frame_error_d;
  logic       rejected_q, rejected_d;

  logic       timeout_expired;

  rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (rx_valid),
    .enable (state_q != S_WAIT_SYNC),
    .expired(timeout_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= S_WAIT_SYNC;
      cmd_q             <= '0;
      payload_q         <= '0;
      start_pulse_q     <= 1'b0;
      dificulty_valid_q <= 1'b0;
      dificulty_q       <= 1'b0;
      move_valid_q      <= 1'b0;
      move_dir_q        <= '0;
      number_valid_q    <= 1'b0;
      number_q          <= '0;
      confirm_pulse_q   <= 1'b0;
      frame_error_q     <= 1'b0;
      rejected_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      cmd_q             <= cmd_d;
      payload_q         <= payload_d;
      start_pulse_q     <= start_pulse_d;
      dificulty_valid_q <= dificulty_valid_d;
      dificulty_q       <= dificulty_d;
      move_valid_q      <= move_valid_d;
      move_dir_q        <= move_dir_d;
      number_valid_q    <= number_valid_d;
      number_q          <= number_d;
      confirm_pulse_q   <= confirm_pulse_d;
      frame_error_q     <= frame_error_d;
      rejected_q        <= rejected_d;
    end
  end

  // SYNC inside a frame is ordinary data: no resync, the checksum catches it
  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      case (state_q)
        S_WAIT_SYNC:   if (rx_data == SYNC_BYTE) state_d = S_GET_CMD;
        S_GET_CMD:     state_d = S_GET_PAYLOAD;
        S_GET_PAYLOAD: state_d = S_GET_CHECK;
        S_GET_CHECK:   state_d = S_WAIT_SYNC;
        default:       state_d = S_WAIT_SYNC;
      endcase
    end else if (timeout_expired) begin
      state_d = S_WAIT_SYNC;
    end
  end

  always_comb begin
    cmd_d             = cmd_q;
    payload_d         = payload_q;
    start_pulse_d     = 1'b0;
    dificulty_valid_d = 1'b0;
    dificulty_d       = dificulty_q;
    move_valid_d      = 1'b0;
    move_dir_d        = move_dir_q;
    number_valid_d    = 1'b0;
    number_d          = number_q;
    confirm_pulse_d   = 1'b0;
    frame_error_d     = 1'b0;
    rejected_d        = 1'b0;

    if (rx_valid) begin
      case (state_q)
        S_GET_CMD:     cmd_d = rx_data;
        S_GET_PAYLOAD: payload_d = rx_data;
        S_GET_CHECK: begin
          if (rx_data != (cmd_q ^ payload_q)) begin
            frame_error_d = 1'b1;
          end else begin
            case (cmd_q)
              OP_START: begin
                if (current_state == INICIAR_JOGO) start_pulse_d = 1'b1;
                else                               rejected_d    = 1'b1;
              end
              OP_DIFFICULTY: begin
                if (current_state == SELECIONAR_DIFICULDADE) begin
                  dificulty_valid_d = 1'b1;
                  dificulty_d       = payload_q[0];
                end else begin
                  rejected_d = 1'b1;
                end
              end
              OP_MOVE: begin
                if (in_play_state(current_state)) begin
                  move_valid_d = 1'b1;
                  move_dir_d   = payload_q[1:0];
                end else begin
                  rejected_d = 1'b1;
                end
              end
              OP_SELECT_NUMBER: begin
                if (in_play_state(current_state) && number_in_range(payload_q)) begin
                  number_valid_d = 1'b1;
                  number_d       = payload_q[3:0];
                end else begin
                  rejected_d = 1'b1;
                end
              end
              OP_CONFIRM: begin
                if (in_play_state(current_state)) confirm_pulse_d = 1'b1;
                else                              rejected_d      = 1'b1;
              end
              default: rejected_d = 1'b1;
            endcase
          end
        end
        default: ;
      endcase
    end else if (timeout_expired) begin
      frame_error_d = 1'b1;
    end
  end

  assign start_pulse     = start_pulse_q;
  assign dificulty_valid = dificulty_valid_q;
  assign dificulty       = dificulty_q;
  assign move_valid      = move_valid_q;
  assign move_dir        = move_dir_q;
  assign number_valid    = number_valid_q;
  assign number          = number_q;
  assign confirm_pulse   = confirm_pulse_q;
  assign frame_error     = frame_error_q;
  assign rejected        = rejected_q;

endmodule

// File: doc/game_command_receiver.md
# game_command_receiver

Receive-side counterpart of the game's UART status transmitter: parses framed command packets arriving from the host over the UART receiver and turns them into single-cycle game-input events. Sits between the UART RX byte interface and the game FSM. It gates each command against the game FSM's current state and reports framing and semantic errors as pulses.

## Interface
Parameters:
- SYNC_BYTE, 8'hAA, frame start marker
- TIMEOUT_CYCLES, 1_000_000, maximum idle clocks between bytes inside a frame
- INICIAR_JOGO, 3'b000; SELECIONAR_DIFICULDADE, 3'b001; CARREGANDO, 3'b010; CORRENDO_MAPA, 3'b011; PERCORRER_NUMEROS, 3'b100; VITORIA, 3'b101; DERROTA, 3'b110. Game FSM state encodings.

Ports:
- clock  in  1  single system clock; one clock domain
- reset  in  1  asynchronous, active-low
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- current_state  in  3  game FSM state
- start_pulse  out  1  START accepted
- dificulty_valid  out  1  DIFFICULTY accepted
- dificulty  out  1  selected difficulty; held until next dificulty_valid
- move_valid  out  1  MOVE accepted
- move_dir  out  2  00 up, 01 down, 10 left, 11 right; held until next move_valid
- number_valid  out  1  SELECT_NUMBER accepted
- number  out  4  1..9; held until next number_valid
- confirm_pulse  out  1  CONFIRM accepted
- frame_error  out  1  checksum mismatch or inter-byte timeout
- rejected  out  1  well-formed frame with unknown opcode, illegal payload, or wrong game state

## Operation
- Frame: SYNC_BYTE, CMD, PAYLOAD, CHECK, where CHECK = CMD ^ PAYLOAD.
- Opcodes: 0x01 START (payload ignored), 0x02 DIFFICULTY (payload[0]), 0x03 MOVE (payload[1:0]), 0x04 SELECT_NUMBER (payload 1..9, else rejected), 0x05 CONFIRM. Any other opcode is rejected.
- State gating:
  - START is accepted only in INICIAR_JOGO.
  - DIFFICULTY is accepted only in SELECIONAR_DIFICULDADE.
  - MOVE, SELECT_NUMBER and CONFIRM are accepted only in CORRENDO_MAPA or PERCORRER_NUMEROS.
  - Otherwise the frame is rejected.
- current_state is sampled on the cycle the CHECK byte is accepted.
- FSM states: S_WAIT_SYNC, S_GET_CMD, S_GET_PAYLOAD, S_GET_CHECK. Bytes are consumed only when rx_valid=1.
  - S_WAIT_SYNC: SYNC_BYTE goes to S_GET_CMD; any other byte is discarded silently.
  - S_GET_CMD stores CMD and goes to S_GET_PAYLOAD. S_GET_PAYLOAD stores PAYLOAD and goes to S_GET_CHECK.
  - S_GET_CHECK returns to S_WAIT_SYNC and evaluates the frame on that same edge.
- A SYNC_BYTE value inside CMD, PAYLOAD or CHECK is treated as data; there is no mid-frame resync. Corruption is caught by the checksum.
- Precedence: a checksum failure gives frame_error only and no rejected. Gating and payload checks apply only to frames whose checksum matches.
- Exactly one of the following pulses per completed frame: start_pulse, dificulty_valid, move_valid, number_valid, confirm_pulse, frame_error, rejected.
- Timeout:
  - A counter clears on every accepted byte and counts each cycle while the FSM is not in S_WAIT_SYNC.
  - When it reaches TIMEOUT_CYCLES-1: go to S_WAIT_SYNC and pulse frame_error.
  - rx_valid on the same cycle wins: the byte is consumed and the counter is cleared.

## Timing
- All outputs are registered. Reset value of every output is 0; FSM starts in S_WAIT_SYNC; counter is 0.
- Latency: the event pulse is high for exactly one cycle, the cycle after the edge that samples CHECK.
- Held outputs (dificulty, move_dir, number) update on the same edge as their valid strobe.
- Back-to-back frames are supported: SYNC_BYTE may arrive on the cycle right after CHECK, including the cycle the pulse is high.
- rx_valid may arrive on consecutive cycles; the block is never busy and applies no backpressure.
- Reset asserted mid-frame: FSM and counter return to the reset state immediately and all outputs clear. Remaining bytes of the broken frame are discarded in S_WAIT_SYNC until the next SYNC_BYTE.

## Structure
- Shared package holds the game state encodings (shared with the transmit-side controller), SYNC_BYTE, the opcode constants and the receiver FSM state encoding.
- One sub-module, rx_timeout_counter:
  - Inputs: clock, reset, clear, enable.
  - Output: expired, a one-cycle strobe.
  - Width: $clog2(TIMEOUT_CYCLES).

## Test plan
- current_state=000, bytes AA 01 00 01 → start_pulse high for one cycle after CHECK; no other pulse.
- current_state=011, bytes AA 03 02 00 (bad checksum; correct is 01) → frame_error pulse; move_valid stays 0; move_dir unchanged.
- current_state=100, bytes AA 04 0A 0E → rejected; number_valid 0. Then AA 04 05 01 sent back-to-back → number_valid with number=5.
- current_state=011, bytes AA 01 00 01 → rejected (wrong state). Then current_state=001, bytes AA 02 01 03 → dificulty_valid with dificulty=1.
- Bytes AA 03 then TIMEOUT_CYCLES idle clocks → frame_error. Trailing 02 01 discarded. Next AA 05 00 05 in state 011 → confirm_pulse.
- Bytes AA 02, reset low for 2 cycles, then 01 03 → all outputs 0 throughout; no pulse from the trailing bytes.
